// File: rtl/multdiv_arbiter.sv
// Round-robin front end that shares one iterative multdiv unit between the CPU
// (port 0) and the game-logic coprocessor (port 1), with a timeout guard.
module multdiv_arbiter #(
  parameter int TAG_W   = 5,
  parameter int TIMEOUT = 40
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req0_valid,
  input  logic             req0_op,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [TAG_W-1:0] req0_tag,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic             req1_op,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             req1_ready,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_exception,
  output logic             rsp_timeout,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [31:0]      md_operandA,
  output logic [31:0]      md_operandB,
  output logic             md_ctrl_MULT,
  output logic             md_ctrl_DIV,
  input  logic [31:0]      md_result,
  input  logic             md_exception,
  input  logic             md_resultRDY,
  output logic             busy
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t           r_state;
  logic             r_last_grant, r_grant, r_busy;
  logic             r_md_mult, r_md_div;
  logic             r_rsp0_valid, r_rsp1_valid, r_rsp_exception, r_rsp_timeout;
  logic [31:0]      r_md_a, r_md_b, r_rsp_result;
  logic [TAG_W-1:0] r_tag, r_rsp_tag;
  logic [CW-1:0]    r_cnt;

  logic             w_idle, w_pick1, w_grant0, w_grant1, w_timeout, w_rsp_done;

  // Readies are gated by reset_n so they read 0 while reset is held.
  assign w_idle     = (r_state == IDLE) && reset_n;
  assign w_pick1    = req1_valid && (!req0_valid || !r_last_grant);
  assign w_grant0   = w_idle && req0_valid && !w_pick1;
  assign w_grant1   = w_idle && w_pick1;
  // The increment that would reach TIMEOUT-1 is the timeout itself.
  assign w_timeout  = (r_cnt == CW'(TIMEOUT - 2));
  assign w_rsp_done = r_grant ? rsp1_ready : rsp0_ready;

  assign req0_ready    = w_grant0;
  assign req1_ready    = w_grant1;
  assign rsp0_valid    = r_rsp0_valid;
  assign rsp1_valid    = r_rsp1_valid;
  assign rsp_result    = r_rsp_result;
  assign rsp_exception = r_rsp_exception;
  assign rsp_timeout   = r_rsp_timeout;
  assign rsp_tag       = r_rsp_tag;
  assign md_operandA   = r_md_a;
  assign md_operandB   = r_md_b;
  assign md_ctrl_MULT  = r_md_mult;
  assign md_ctrl_DIV   = r_md_div;
  assign busy          = r_busy;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= IDLE;
      r_last_grant    <= 1'b1;
      r_grant         <= 1'b0;
      r_busy          <= 1'b0;
      r_md_mult       <= 1'b0;
      r_md_div        <= 1'b0;
      r_md_a          <= '0;
      r_md_b          <= '0;
      r_tag           <= '0;
      r_cnt           <= '0;
      r_rsp0_valid    <= 1'b0;
      r_rsp1_valid    <= 1'b0;
      r_rsp_result    <= '0;
      r_rsp_exception <= 1'b0;
      r_rsp_timeout   <= 1'b0;
      r_rsp_tag       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant0 || w_grant1) begin
            r_grant      <= w_grant1;
            r_last_grant <= w_grant1;
            r_md_a       <= w_grant1 ? req1_a : req0_a;
            r_md_b       <= w_grant1 ? req1_b : req0_b;
            r_tag        <= w_grant1 ? req1_tag : req0_tag;
            r_md_mult    <= w_grant1 ? !req1_op : !req0_op;
            r_md_div     <= w_grant1 ? req1_op : req0_op;
            r_busy       <= 1'b1;
            r_state      <= START;
          end
        end
        START: begin
          r_md_mult <= 1'b0;
          r_md_div  <= 1'b0;
          r_cnt     <= '0;
          r_state   <= WAIT;
        end
        WAIT: begin
          if (md_resultRDY || w_timeout) begin
            r_rsp_result    <= md_resultRDY ? md_result : '0;
            r_rsp_exception <= md_resultRDY ? md_exception : 1'b1;
            r_rsp_timeout   <= !md_resultRDY;
            r_rsp_tag       <= r_tag;
            r_rsp0_valid    <= !r_grant;
            r_rsp1_valid    <= r_grant;
            r_md_a          <= '0;
            r_md_b          <= '0;
            r_state         <= RESP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        RESP: begin
          if (w_rsp_done) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_arbiter.sv
// Directed bench for multdiv_arbiter with a behavioural multdiv of programmable latency.
module tb_multdiv_arbiter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        req0_valid = 0, req0_op = 0, req1_valid = 0, req1_op = 0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [4:0]  req0_tag = '0, req1_tag = '0;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 0, rsp1_ready = 0;
  logic [31:0] rsp_result, md_operandA, md_operandB;
  logic        rsp_exception, rsp_timeout, md_ctrl_MULT, md_ctrl_DIV, busy;
  logic [4:0]  rsp_tag;
  logic [31:0] md_result = '0;
  logic        md_exception = 0, md_resultRDY = 0;

  int vectors = 0, miscompares = 0;
  int md_lat = -1, md_rem = 0;
  int n_mult = 0, n_div = 0, n_both = 0, n_rdy0 = 0, n_rdy1 = 0, n_rsp0 = 0, n_rsp1 = 0;
  int glog[$];

  multdiv_arbiter #(.TAG_W(5), .TIMEOUT(40)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req0_tag(req0_tag), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .req1_tag(req1_tag), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_exception(rsp_exception), .rsp_timeout(rsp_timeout),
    .rsp_tag(rsp_tag), .md_operandA(md_operandA), .md_operandB(md_operandB),
    .md_ctrl_MULT(md_ctrl_MULT), .md_ctrl_DIV(md_ctrl_DIV), .md_result(md_result),
    .md_exception(md_exception), .md_resultRDY(md_resultRDY), .busy(busy)
  );

  always #5 clock = ~clock;

  // Multdiv model: RDY is high for one cycle, md_lat cycles after the start-pulse cycle.
  logic [31:0] m_res;
  logic        m_exc;
  always @(posedge clock) begin
    #1;
    md_resultRDY = 1'b0;
    if (!reset_n) begin
      md_rem = 0;
    end else if (md_ctrl_MULT || md_ctrl_DIV) begin
      if (md_ctrl_DIV) begin
        m_exc = (md_operandB == 0);
        m_res = m_exc ? '0 : 32'($signed(md_operandA) / $signed(md_operandB));
      end else begin
        m_exc = 1'b0;
        m_res = 32'($signed(md_operandA) * $signed(md_operandB));
      end
      md_rem = md_lat;
    end else if (md_rem > 0) begin
      md_rem = md_rem - 1;
      if (md_rem == 0) begin
        md_resultRDY = 1'b1;
        md_result    = m_res;
        md_exception = m_exc;
      end
    end
  end

  always @(negedge clock) begin
    if (md_ctrl_MULT) n_mult++;
    if (md_ctrl_DIV) n_div++;
    if (md_ctrl_MULT && md_ctrl_DIV) n_both++;
    if (req0_ready) begin n_rdy0++; glog.push_back(0); end
    if (req1_ready) begin n_rdy1++; glog.push_back(1); end
    if (rsp0_valid) n_rsp0++;
    if (rsp1_valid) n_rsp1++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_rsp(input int port, output int n);
    n = 0;
    while (((port == 0) ? !rsp0_valid : !rsp1_valid) && n < 100) begin
      step();
      n++;
    end
  endtask

  int n, base, s0, s1, sm, sd, snap;

  initial begin
    // Reset with both requests pending: everything must read 0.
    #1 reset_n = 1'b0;
    req0_valid = 1; req1_valid = 1;
    #2;
    chk("rst_rdy0", 32'(req0_ready), 0);
    chk("rst_rdy1", 32'(req1_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ctrl", 32'({md_ctrl_MULT, md_ctrl_DIV}), 0);
    chk("rst_rspv", 32'({rsp0_valid, rsp1_valid}), 0);
    chk("rst_opA", md_operandA, 0);
    req0_valid = 0; req1_valid = 0;
    step(); step();
    reset_n = 1'b1;
    step();

    // Single multiply on port 0.
    md_lat = 33; sm = n_mult;
    req0_valid = 1; req0_op = 0; req0_a = 7; req0_b = -32'sd6; req0_tag = 3;
    #1;
    chk("t1_rdy0", 32'(req0_ready), 1);
    chk("t1_rdy1", 32'(req1_ready), 0);
    step(); req0_valid = 0;
    chk("t1_mult", 32'(md_ctrl_MULT), 1);
    chk("t1_div", 32'(md_ctrl_DIV), 0);
    chk("t1_opA", md_operandA, 7);
    wait_rsp(0, n);
    chk("t1_lat", 32'(n), 34);
    chk("t1_res", rsp_result, 32'hFFFF_FFD6);
    chk("t1_exc", 32'(rsp_exception), 0);
    chk("t1_to", 32'(rsp_timeout), 0);
    chk("t1_tag", 32'(rsp_tag), 3);
    rsp0_ready = 1; step(); rsp0_ready = 0;
    chk("t1_idle", 32'({busy, rsp0_valid}), 0);
    chk("t1_npulse", 32'(n_mult - sm), 1);
    chk("t1_rsp1", 32'(n_rsp1), 0);

    // Divide by zero on port 1.
    md_lat = 5; sd = n_div;
    req1_valid = 1; req1_op = 1; req1_a = 100; req1_b = 0; req1_tag = 17;
    #1;
    chk("t2_rdy1", 32'(req1_ready), 1);
    step(); req1_valid = 0;
    chk("t2_ctrl", 32'({md_ctrl_MULT, md_ctrl_DIV}), 1);
    wait_rsp(1, n);
    chk("t2_lat", 32'(n), 6);
    chk("t2_exc", 32'(rsp_exception), 1);
    chk("t2_to", 32'(rsp_timeout), 0);
    chk("t2_tag", 32'(rsp_tag), 17);
    chk("t2_rsp0", 32'(rsp0_valid), 0);
    rsp1_ready = 1; step(); rsp1_ready = 0;
    chk("t2_npulse", 32'(n_div - sd), 1);

    // Four back-to-back operations with both ports always requesting.
    md_lat = 2; base = glog.size(); s0 = n_rdy0; s1 = n_rdy1;
    req0_op = 0; req0_a = 3; req0_b = 4; req0_tag = 5;
    req1_op = 1; req1_a = 50; req1_b = 7; req1_tag = 9;
    req0_valid = 1; req1_valid = 1; rsp0_ready = 1; rsp1_ready = 1;
    n = 0;
    while (glog.size() - base < 4 && n < 100) begin step(); n++; end
    req0_valid = 0; req1_valid = 0;
    n = 0;
    while (busy && n < 50) begin step(); n++; end
    chk("t3_busy", 32'(busy), 0);
    for (int i = 0; i < 4; i++)
      chk("t3_grant", (base + i < glog.size()) ? 32'(glog[base + i]) : 32'hFFFF_FFFF, 32'(i % 2));
    chk("t3_rdy0", 32'(n_rdy0 - s0), 2);
    chk("t3_rdy1", 32'(n_rdy1 - s1), 2);
    chk("t3_both", 32'(n_both), 0);
    rsp0_ready = 0; rsp1_ready = 0;

    // Backpressure on port 0 while both ports wait with new requests.
    md_lat = 3;
    req0_op = 0; req0_a = -32'sd5; req0_b = -32'sd9; req0_tag = 30;
    req0_valid = 1;
    step(); req0_valid = 0;
    wait_rsp(0, n);
    chk("t4_lat", 32'(n), 4);
    req1_op = 0; req1_a = 6; req1_b = 7; req1_tag = 2;
    req0_valid = 1; req1_valid = 1;
    #1;
    for (int i = 0; i < 10; i++) begin
      chk("t4_res", rsp_result, 45);
      chk("t4_tag", 32'(rsp_tag), 30);
      chk("t4_rdys", 32'({req0_ready, req1_ready}), 0);
      chk("t4_busy", 32'({busy, rsp0_valid}), 3);
      step();
    end
    rsp0_ready = 1; step(); rsp0_ready = 0;
    #1;
    chk("t4_rsp0", 32'(rsp0_valid), 0);
    chk("t4_rdy1", 32'(req1_ready), 1);
    chk("t4_rdy0", 32'(req0_ready), 0);
    step(); req0_valid = 0; req1_valid = 0;
    wait_rsp(1, n);
    chk("t4_res1", rsp_result, 42);
    chk("t4_tag1", 32'(rsp_tag), 2);
    rsp1_ready = 1; step(); rsp1_ready = 0;

    // Timeout with no RDY, then RDY on the exact timeout cycle.
    md_lat = -1;
    req0_op = 0; req0_a = 1; req0_b = 1; req0_tag = 11; req0_valid = 1;
    step(); req0_valid = 0;
    wait_rsp(0, n);
    chk("t5_lat", 32'(n), 40);
    chk("t5_res", rsp_result, 0);
    chk("t5_exc", 32'(rsp_exception), 1);
    chk("t5_to", 32'(rsp_timeout), 1);
    chk("t5_tag", 32'(rsp_tag), 11);
    rsp0_ready = 1; step(); rsp0_ready = 0;
    md_lat = 39;
    req1_op = 0; req1_a = 9; req1_b = 9; req1_tag = 4; req1_valid = 1;
    step(); req1_valid = 0;
    wait_rsp(1, n);
    chk("t5c_lat", 32'(n), 40);
    chk("t5c_res", rsp_result, 81);
    chk("t5c_exc", 32'(rsp_exception), 0);
    chk("t5c_to", 32'(rsp_timeout), 0);
    rsp1_ready = 1; step(); rsp1_ready = 0;

    // Asynchronous reset in the middle of WAIT.
    md_lat = 20;
    req0_op = 0; req0_a = 2; req0_b = 3; req0_tag = 1;
    req1_op = 1; req1_a = 8; req1_b = 2; req1_tag = 7;
    req0_valid = 1;
    step(); req0_valid = 0;
    repeat (5) step();
    chk("t6_busy", 32'(busy), 1);
    chk("t6_opA", md_operandA, 2);
    chk("t6_opB", md_operandB, 3);
    snap = n_rsp0;
    #2 reset_n = 1'b0;
    req0_valid = 1; req1_valid = 1;
    #1;
    chk("t6_rbusy", 32'(busy), 0);
    chk("t6_ropA", md_operandA, 0);
    chk("t6_rrdys", 32'({req0_ready, req1_ready}), 0);
    chk("t6_rrsp", 32'({rsp0_valid, rsp1_valid, rsp_result}), 0);
    step(); step();
    reset_n = 1'b1; md_lat = 2;
    #1;
    chk("t6_tie0", 32'({req0_ready, req1_ready}), 2);
    step(); req0_valid = 0; req1_valid = 0;
    wait_rsp(0, n);
    chk("t6_lat", 32'(n), 3);
    chk("t6_res", rsp_result, 6);
    chk("t6_tag", 32'(rsp_tag), 1);
    rsp0_ready = 1; step(); rsp0_ready = 0;
    chk("t6_nrsp", 32'(n_rsp0 - snap), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
